// File: rtl/key_debounce_pulse.sv
// rtl/key_debounce_pulse.sv - push-button debouncer with registered level and press/release strobes
module key_debounce_pulse #(
    parameter int DEBOUNCE_CYCLES = 2000000,
    parameter int CNT_W           = 21
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHK,
        PRESSED,
        RELEASE_CHK
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sync1_q, sync1_d;
    logic               key_s_q, key_s_d;
    logic               key_level_q, key_level_d;
    logic               press_q, press_d;
    logic               release_q, release_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sync1_q     <= 1'b0;
            key_s_q     <= 1'b0;
            key_level_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sync1_q     <= sync1_d;
            key_s_q     <= key_s_d;
            key_level_q <= key_level_d;
            press_q     <= press_d;
            release_q   <= release_d;
        end
    end

    always_comb begin
        sync1_d     = key_in;
        key_s_d     = sync1_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        key_level_d = key_level_q;
        press_d     = 1'b0;
        release_d   = 1'b0;

        // Any sample disagreeing with the candidate level restarts qualification.
        case (state_q)
            IDLE: begin
                if (key_s_q) begin
                    state_d = PRESS_CHK;
                    cnt_d   = '0;
                end
            end
            PRESS_CHK: begin
                if (!key_s_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = PRESSED;
                    cnt_d       = '0;
                    press_d     = 1'b1;
                    key_level_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!key_s_q) begin
                    state_d = RELEASE_CHK;
                    cnt_d   = '0;
                end
            end
            RELEASE_CHK: begin
                if (key_s_q) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    release_d   = 1'b1;
                    key_level_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign key_level     = key_level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

endmodule

// File: tb/tb_key_debounce_pulse.sv
// tb/tb_key_debounce_pulse.sv - self-checking bench for key_debounce_pulse with run-length reference model
module tb_key_debounce_pulse;

    localparam int D = 4;

    logic clk;
    logic rst;
    logic key_in;
    logic key_level;
    logic press_pulse;
    logic release_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    key_debounce_pulse #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key_in(key_in),
        .key_level(key_level),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the synchroniser is a two-sample delay line; a level change is accepted
    // once D+1 consecutive delayed samples disagree with the current level.
    logic m_s1 = 1'b0, m_s2 = 1'b0;
    logic m_level = 1'b0, m_press = 1'b0, m_release = 1'b0;
    int   m_run = 0;

    always @(posedge clk) begin
        logic s;
        if (rst) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_level = 1'b0;
            m_press = 1'b0; m_release = 1'b0; m_run = 0;
        end else begin
            s = m_s2;
            m_s2 = m_s1;
            m_s1 = key_in;
            m_press = 1'b0;
            m_release = 1'b0;
            if (s != m_level) begin
                m_run = m_run + 1;
                if (m_run == D + 1) begin
                    m_level = s;
                    m_run = 0;
                    if (s) m_press = 1'b1;
                    else   m_release = 1'b1;
                end
            end else begin
                m_run = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            n_checks++;
            if (press_pulse === 1'b1 && release_pulse === 1'b1) begin
                n_fail++;
                $display("FAIL both_pulses: press=%b release=%b, required not both 1", press_pulse, release_pulse);
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        key_in = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); @(negedge clk);
            n_checks++;
            if ({key_level, press_pulse, release_pulse} !== 3'b000) begin
                n_fail++;
                $display("FAIL reset cyc %0d: got %b%b%b required 000", c, key_level, press_pulse, release_pulse);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_clean_press();
        key_in = 1'b1;
        for (int e = 0; e < 10; e++) begin
            @(posedge clk); @(negedge clk);
            n_checks++;
            if (press_pulse !== (e == D + 2) || key_level !== (e >= D + 2) || release_pulse !== 1'b0) begin
                n_fail++;
                $display("FAIL clean_press edge %0d: got lvl=%b p=%b r=%b required lvl=%b p=%b r=0",
                         e, key_level, press_pulse, release_pulse, e >= D + 2, e == D + 2);
            end
        end
    endtask

    task automatic test_clean_release();
        key_in = 1'b0;
        for (int e = 0; e < 10; e++) begin
            @(posedge clk); @(negedge clk);
            n_checks++;
            if (release_pulse !== (e == D + 2) || key_level !== (e < D + 2) || press_pulse !== 1'b0) begin
                n_fail++;
                $display("FAIL clean_release edge %0d: got lvl=%b p=%b r=%b required lvl=%b p=0 r=%b",
                         e, key_level, press_pulse, release_pulse, e < D + 2, e == D + 2);
            end
        end
    endtask

    task automatic test_bounce();
        int presses = 0;
        for (int c = 0; c < 14; c++) begin
            key_in = (c != 3);
            @(posedge clk); @(negedge clk);
            presses += int'(press_pulse === 1'b1);
            n_checks++;
            if (press_pulse !== (c == 4 + D + 2) || release_pulse !== 1'b0) begin
                n_fail++;
                $display("FAIL bounce cyc %0d: got p=%b r=%b required p=%b r=0",
                         c, press_pulse, release_pulse, c == 4 + D + 2);
            end
            n_checks++;
            if ({key_level, press_pulse, release_pulse} !== {m_level, m_press, m_release}) begin
                n_fail++;
                $display("FAIL bounce_model cyc %0d: got %b%b%b required %b%b%b", c,
                         key_level, press_pulse, release_pulse, m_level, m_press, m_release);
            end
        end
        n_checks++;
        if (presses != 1) begin
            n_fail++;
            $display("FAIL bounce_count: got %0d press pulses required 1", presses);
        end
    endtask

    task automatic test_release_glitch();
        for (int c = 0; c < 14; c++) begin
            key_in = (c == 2);
            @(posedge clk); @(negedge clk);
            n_checks++;
            if (release_pulse !== (c == 3 + D + 2) || key_level !== (c < 3 + D + 2) || press_pulse !== 1'b0) begin
                n_fail++;
                $display("FAIL release_glitch cyc %0d: got lvl=%b p=%b r=%b required lvl=%b p=0 r=%b",
                         c, key_level, press_pulse, release_pulse, c < 3 + D + 2, c == 3 + D + 2);
            end
        end
    endtask

    task automatic test_reset_mid();
        key_in = 1'b1;
        for (int c = 0; c < 16; c++) begin
            rst = (c == 4);
            @(posedge clk); @(negedge clk);
            n_checks++;
            if (press_pulse !== (c == 5 + D + 2) || key_level !== (c >= 5 + D + 2) || release_pulse !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid cyc %0d: got lvl=%b p=%b r=%b required lvl=%b p=%b r=0",
                         c, key_level, press_pulse, release_pulse, c >= 5 + D + 2, c == 5 + D + 2);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        int np = 0, nr = 0;
        logic prev_p = 1'b0, prev_r = 1'b0;
        key_in = 1'b0;
        repeat (12) @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            key_in = (k % 2 == 0);
            for (int c = 0; c < 12; c++) begin
                @(posedge clk); @(negedge clk);
                np += int'(press_pulse === 1'b1);
                nr += int'(release_pulse === 1'b1);
                n_checks++;
                if ((prev_p && press_pulse) || (prev_r && release_pulse)) begin
                    n_fail++;
                    $display("FAIL pulse_width k %0d cyc %0d: pulse high on two consecutive cycles", k, c);
                end
                prev_p = press_pulse;
                prev_r = release_pulse;
                n_checks++;
                if ({key_level, press_pulse, release_pulse} !== {m_level, m_press, m_release}) begin
                    n_fail++;
                    $display("FAIL b2b_model k %0d cyc %0d: got %b%b%b required %b%b%b", k, c,
                             key_level, press_pulse, release_pulse, m_level, m_press, m_release);
                end
            end
        end
        n_checks++;
        if (np != 10 || nr != 10) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d press / %0d release required 10 / 10", np, nr);
        end
    endtask

    task automatic test_random();
        for (int seg = 0; seg < 60; seg++) begin
            int len;
            key_in = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 9);
            for (int c = 0; c < len; c++) begin
                rst = ($urandom_range(0, 39) == 0);
                @(posedge clk); @(negedge clk);
                n_checks++;
                if ({key_level, press_pulse, release_pulse} !== {m_level, m_press, m_release}) begin
                    n_fail++;
                    $display("FAIL random_model seg %0d cyc %0d: got %b%b%b required %b%b%b", seg, c,
                             key_level, press_pulse, release_pulse, m_level, m_press, m_release);
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        key_in = 1'b0;
        @(negedge clk);
        test_reset();
        test_clean_press();
        test_clean_release();
        test_bounce();
        test_release_glitch();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
